reset_sequencer: RTL and testbench

- Consumes the clock generator's lock indication and the DDR2 calibration status.
- Releases resets in a fixed order: DDR2 interface first, then Wishbone fabric, then CPU.
- Re-asserts resets on loss of lock, DDR2 calibration timeout, or a software reset request.
- Sits beside the clock/reset generator and drives every downstream reset in the SoC.

---
 rtl/reset_sequencer_pkg.sv | 32 +++
 rtl/reset_sequencer_sync_2ff.sv | 21 ++
 rtl/reset_sequencer.sv | 125 ++++++++++++
 tb/tb_reset_sequencer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/reset_sequencer_pkg.sv
// rtl/reset_sequencer_pkg.sv - state encodings, counter widths and reset decode helpers
package reset_sequencer_pkg;

  localparam int TIMER_W = 16;
  localparam int LLC_W   = 8;
  localparam int RETRY_W = 2;

  localparam logic [2:0] ST_WAIT_LOCK  = 3'd0;
  localparam logic [2:0] ST_STABLE     = 3'd1;
  localparam logic [2:0] ST_REL_DDR2   = 3'd2;
  localparam logic [2:0] ST_WAIT_CALIB = 3'd3;
  localparam logic [2:0] ST_REL_WB     = 3'd4;
  localparam logic [2:0] ST_RUN        = 3'd5;
  localparam logic [2:0] ST_SW_HOLD    = 3'd6;
  localparam logic [2:0] ST_FAULT      = 3'd7;

  // Reset levels are a pure function of the state being entered, which keeps
  // the ddr2 -> wb -> cpu ordering true by construction.
  function automatic logic ddr2_held(input logic [2:0] st);
    return (st == ST_WAIT_LOCK) || (st == ST_STABLE) ||
           (st == ST_REL_DDR2) || (st == ST_FAULT);
  endfunction

  function automatic logic wb_held(input logic [2:0] st);
    return (st != ST_REL_WB) && (st != ST_RUN);
  endfunction

  function automatic logic cpu_held(input logic [2:0] st);
    return st != ST_RUN;
  endfunction

endpackage

// File: rtl/reset_sequencer_sync_2ff.sv
// rtl/reset_sequencer_sync_2ff.sv - single-bit two-flop synchroniser with synchronous clear
module sync_2ff (
  input  logic clk,
  input  logic clr_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - ordered release of DDR2, Wishbone and CPU resets
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int CALIB_TIMEOUT      = 65535,
  parameter int WB_TO_CPU_CYCLES   = 16,
  parameter int SW_HOLD_CYCLES     = 32,
  parameter int MAX_RETRIES        = 3
) (
  input  logic               wb_clk_i,
  input  logic               rst_n_i,
  input  logic               pll_locked_i,
  input  logic               ddr2_calib_done_i,
  input  logic               sw_rst_req_i,
  output logic               ddr2_rst_o,
  output logic               wb_rst_o,
  output logic               cpu_rst_o,
  output logic [2:0]         state_o,
  output logic [LLC_W-1:0]   lock_loss_cnt_o,
  output logic [RETRY_W-1:0] retry_cnt_o,
  output logic               fault_o
);

  if (LOCK_STABLE_CYCLES < 1 || LOCK_STABLE_CYCLES > 65535 ||
      CALIB_TIMEOUT < 1 || CALIB_TIMEOUT > 65535 ||
      WB_TO_CPU_CYCLES < 1 || WB_TO_CPU_CYCLES > 65535 ||
      SW_HOLD_CYCLES < 1 || SW_HOLD_CYCLES > 65535 ||
      MAX_RETRIES < 0 || MAX_RETRIES > 3) begin : g_param_check
    $error("reset_sequencer: parameter out of range");
  end

  localparam logic [TIMER_W-1:0] LOCK_LAST  = TIMER_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] CALIB_LAST = TIMER_W'(CALIB_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] WB_LAST    = TIMER_W'(WB_TO_CPU_CYCLES - 1);
  localparam logic [TIMER_W-1:0] HOLD_LAST  = TIMER_W'(SW_HOLD_CYCLES - 1);

  logic               lk, cd;
  logic [2:0]         state, state_d;
  logic [TIMER_W-1:0] timer, timer_d;
  logic [RETRY_W-1:0] retry_d;
  logic               lock_lost;

  sync_2ff u_sync_lock  (.clk(wb_clk_i), .clr_n(rst_n_i), .d(pll_locked_i),      .q(lk));
  sync_2ff u_sync_calib (.clk(wb_clk_i), .clr_n(rst_n_i), .d(ddr2_calib_done_i), .q(cd));

  always_comb begin
    state_d   = state;
    timer_d   = timer;
    retry_d   = retry_cnt_o;
    lock_lost = 1'b0;
    // Lock loss outranks every other transition, timeouts and sw requests included.
    if (!lk && state != ST_WAIT_LOCK && state != ST_FAULT) begin
      state_d   = ST_WAIT_LOCK;
      timer_d   = '0;
      lock_lost = 1'b1;
    end else begin
      case (state)
        ST_WAIT_LOCK: if (lk) begin
          state_d = ST_STABLE;
          timer_d = '0;
        end
        ST_STABLE: if (timer == LOCK_LAST) begin
          state_d = ST_REL_DDR2;
          timer_d = '0;
        end else timer_d = timer + 1'b1;
        ST_REL_DDR2: begin
          state_d = ST_WAIT_CALIB;
          timer_d = '0;
        end
        ST_WAIT_CALIB: if (cd) begin
          state_d = ST_REL_WB;
          timer_d = '0;
        end else if (timer == CALIB_LAST) begin
          timer_d = '0;
          if (int'(retry_cnt_o) < MAX_RETRIES) begin
            retry_d = retry_cnt_o + 1'b1;
            state_d = ST_STABLE;
          end else state_d = ST_FAULT;
        end else timer_d = timer + 1'b1;
        ST_REL_WB: if (timer == WB_LAST) begin
          state_d = ST_RUN;
          timer_d = '0;
          retry_d = '0;
        end else timer_d = timer + 1'b1;
        ST_RUN: if (sw_rst_req_i) begin
          state_d = ST_SW_HOLD;
          timer_d = '0;
        end
        ST_SW_HOLD: if (sw_rst_req_i) timer_d = '0;
        else if (timer == HOLD_LAST) begin
          state_d = ST_REL_WB;
          timer_d = '0;
        end else timer_d = timer + 1'b1;
        default: state_d = ST_FAULT;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (!rst_n_i) begin
      state           <= ST_WAIT_LOCK;
      timer           <= '0;
      retry_cnt_o     <= '0;
      lock_loss_cnt_o <= '0;
      ddr2_rst_o      <= 1'b1;
      wb_rst_o        <= 1'b1;
      cpu_rst_o       <= 1'b1;
      fault_o         <= 1'b0;
    end else begin
      state       <= state_d;
      timer       <= timer_d;
      retry_cnt_o <= retry_d;
      if (lock_lost && lock_loss_cnt_o != {LLC_W{1'b1}})
        lock_loss_cnt_o <= lock_loss_cnt_o + 1'b1;
      ddr2_rst_o  <= ddr2_held(state_d);
      wb_rst_o    <= wb_held(state_d);
      cpu_rst_o   <= cpu_held(state_d);
      fault_o     <= (state_d == ST_FAULT);
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - directed self-checking bench for reset_sequencer
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst_n, pll, cdone, sw;
  logic       ddr2_rst, wb_rst, cpu_rst, fault;
  logic [2:0] state;
  logic [7:0] llc;
  logic [1:0] retry;

  int vectors = 0;
  int miscompares = 0;
  int n, n2;

  always #5 clk = ~clk;

  reset_sequencer #(.CALIB_TIMEOUT(100)) dut (
    .wb_clk_i(clk), .rst_n_i(rst_n), .pll_locked_i(pll),
    .ddr2_calib_done_i(cdone), .sw_rst_req_i(sw),
    .ddr2_rst_o(ddr2_rst), .wb_rst_o(wb_rst), .cpu_rst_o(cpu_rst),
    .state_o(state), .lock_loss_cnt_o(llc), .retry_cnt_o(retry), .fault_o(fault)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Every clock advance samples 1 time unit after the edge and checks ordering.
  task automatic tick();
    @(posedge clk);
    #1;
    chk("order_ddr2_wb", {31'd0, ddr2_rst & ~wb_rst}, 32'd0);
    chk("order_wb_cpu", {31'd0, wb_rst & ~cpu_rst}, 32'd0);
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0: return ddr2_rst;
      1: return wb_rst;
      2: return cpu_rst;
      default: return fault;
    endcase
  endfunction

  task automatic count_until(input int sel, input logic level, input int limit, output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (sig(sel) !== level && cnt < limit);
  endtask

  task automatic wait_state(input logic [2:0] exp, input int limit, input string tag);
    int k = 0;
    while (state !== exp && k < limit) begin
      tick();
      k++;
    end
    chk(tag, {29'd0, state}, {29'd0, exp});
  endtask

  initial begin
    rst_n = 1'b0; pll = 1'b0; cdone = 1'b0; sw = 1'b0;
    repeat (5) tick();
    chk("rst_state", state, 0);
    chk("rst_ddr2", ddr2_rst, 1);
    chk("rst_wb", wb_rst, 1);
    chk("rst_cpu", cpu_rst, 1);
    chk("rst_llc", llc, 0);
    chk("rst_retry", retry, 0);
    chk("rst_fault", fault, 0);
    rst_n = 1'b1;

    // Lock, then glitch it for three cycles while the stability timer is at 500.
    pll = 1'b1; cdone = 1'b1;
    wait_state(3'd1, 10, "enter_stable");
    repeat (500) tick();
    pll = 1'b0;
    tick(); tick();
    chk("glitch_still_stable", state, 1);
    tick();
    chk("glitch_wait_lock", state, 0);
    chk("glitch_llc", llc, 1);
    chk("glitch_ddr2", ddr2_rst, 1);
    pll = 1'b1;

    // Full power-up timing from the first edge that samples the relock.
    tick();
    count_until(0, 1'b0, 1100, n);
    chk("pwr_ddr2_fall", n, 2 + 1024 + 1);
    count_until(1, 1'b0, 10, n);
    chk("pwr_wb_fall", n, 1);
    count_until(2, 1'b0, 40, n);
    chk("pwr_cpu_fall", n, 16);
    chk("pwr_state_run", state, 5);
    chk("pwr_retry", retry, 0);
    chk("pwr_fault", fault, 0);

    // Single software reset request.
    sw = 1'b1; tick(); sw = 1'b0;
    chk("sw_state", state, 6);
    chk("sw_wb", wb_rst, 1);
    chk("sw_cpu", cpu_rst, 1);
    chk("sw_ddr2", ddr2_rst, 0);
    count_until(1, 1'b0, 60, n);
    chk("sw_hold_len", n, 32);
    chk("sw_ddr2_after", ddr2_rst, 0);
    chk("sw_cpu_after", cpu_rst, 1);
    wait_state(3'd5, 40, "sw_back_run");

    // Second request at hold cycle 20 restarts the hold.
    sw = 1'b1; tick(); sw = 1'b0;
    repeat (19) tick();
    chk("sw2_mid_wb", wb_rst, 1);
    sw = 1'b1; tick(); sw = 1'b0;
    count_until(1, 1'b0, 60, n2);
    chk("sw2_hold_len", 20 + n2, 52);
    wait_state(3'd5, 40, "sw2_back_run");

    // Lock loss in RUN becomes visible after the synchroniser delay.
    pll = 1'b0;
    tick();
    chk("run_loss_e1", state, 5);
    tick();
    chk("run_loss_e2", state, 5);
    tick();
    chk("run_loss_state", state, 0);
    chk("run_loss_ddr2", ddr2_rst, 1);
    chk("run_loss_wb", wb_rst, 1);
    chk("run_loss_cpu", cpu_rst, 1);
    chk("run_loss_llc", llc, 2);
    pll = 1'b1;
    wait_state(3'd5, 1200, "relock_run");

    // Software request and lock loss seen on the same edge.
    pll = 1'b0;
    tick(); tick();
    sw = 1'b1; tick(); sw = 1'b0;
    chk("simul_state", state, 0);
    chk("simul_ddr2", ddr2_rst, 1);
    chk("simul_llc", llc, 3);

    // Drive the loss count to 300 events; it must stop at 255.
    for (int i = 4; i <= 300; i++) begin
      pll = 1'b1;
      wait_state(3'd1, 10, "sat_stable");
      pll = 1'b0;
      wait_state(3'd0, 10, "sat_wait_lock");
      chk("sat_llc", llc, (i > 255) ? 255 : i);
    end

    // Calibration never completes: three retries then FAULT.
    rst_n = 1'b0; cdone = 1'b0; pll = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    chk("cal_rst_llc", llc, 0);
    pll = 1'b1;
    count_until(0, 1'b0, 1100, n);
    chk("cal_first_release", ddr2_rst, 0);
    for (int k = 1; k <= 3; k++) begin
      count_until(0, 1'b1, 200, n);
      chk("cal_timeout_len", n, 100);
      chk("cal_retry_cnt", retry, k);
      chk("cal_retry_state", state, 1);
      count_until(0, 1'b0, 1100, n);
      chk("cal_rerelease_len", n, 1025);
    end
    count_until(3, 1'b1, 200, n);
    chk("fault_len", n, 100);
    chk("fault_state", state, 7);
    chk("fault_ddr2", ddr2_rst, 1);
    chk("fault_wb", wb_rst, 1);
    chk("fault_cpu", cpu_rst, 1);
    chk("fault_retry", retry, 3);

    // FAULT ignores lock, calibration and software requests.
    pll = 1'b0;
    repeat (5) tick();
    pll = 1'b1; cdone = 1'b1;
    repeat (5) tick();
    sw = 1'b1; tick(); sw = 1'b0;
    repeat (10) tick();
    chk("fault_sticky_state", state, 7);
    chk("fault_sticky_flag", fault, 1);
    chk("fault_sticky_llc", llc, 0);

    rst_n = 1'b0;
    tick();
    chk("fault_clr_state", state, 0);
    chk("fault_clr_flag", fault, 0);
    chk("fault_clr_retry", retry, 0);
    chk("fault_clr_ddr2", ddr2_rst, 1);
    rst_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
